// File: rtl/vga_timing_pkg.sv
// Shared defaults for the 640x480@60 VGA timing generator.
// Also holds the position type and the region-window helper.
package vga_timing_pkg;

  localparam int DefHActive = 640;
  localparam int DefHFp     = 16;
  localparam int DefHSync   = 96;
  localparam int DefHBp     = 48;

  localparam int DefVActive = 480;
  localparam int DefVFp     = 10;
  localparam int DefVSync   = 2;
  localparam int DefVBp     = 33;

  localparam bit DefHsPol = 1'b0;
  localparam bit DefVsPol = 1'b0;

  localparam int PosWidth = 12;
  typedef logic [PosWidth-1:0] pos_t;

  // True when lo <= pos < hi.
  function automatic logic inWindow(pos_t pos, int lo, int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing outputs of vga_timing, as seen by the producer (master)
// and by downstream pixel logic (slave).
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic o_hs;
  logic o_vs;
  logic o_frame;
  pos_t o_h;
  pos_t o_v;
  logic o_de;

  modport master (output o_hs, o_vs, o_frame, o_h, o_v, o_de);
  modport slave  (input  o_hs, o_vs, o_frame, o_h, o_v, o_de);

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with zero-latency sync, display-enable
// and start-of-frame decodes. Position 0 on each axis is the first active pixel/line.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DefHActive,
  parameter int H_FP     = DefHFp,
  parameter int H_SYNC   = DefHSync,
  parameter int H_BP     = DefHBp,
  parameter int V_ACTIVE = DefVActive,
  parameter int V_FP     = DefVFp,
  parameter int V_SYNC   = DefVSync,
  parameter int V_BP     = DefVBp,
  parameter bit HS_POL   = DefHsPol,
  parameter bit VS_POL   = DefVsPol
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Declaration initialisers give a defined power-up raster in simulation
  // and on FPGA targets that honour register init values.
  pos_t hCnt = '0;
  pos_t vCnt = '0;

  logic hWrap;
  logic vWrap;

  assign hWrap = (hCnt == pos_t'(H_TOTAL - 1));
  assign vWrap = (vCnt == pos_t'(V_TOTAL - 1));

  // NOTE: registered state uses non-blocking assignments so every always_ff
  // samples the pre-edge value of hCnt/vCnt regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hWrap) begin
      hCnt <= '0;
      vCnt <= vWrap ? '0 : vCnt + pos_t'(1);
    end else begin
      hCnt <= hCnt + pos_t'(1);
    end
  end

  // Decodes are taken straight from the counter registers so they line up
  // with o_h/o_v on the same cycle.
  assign vga.o_h     = hCnt;
  assign vga.o_v     = vCnt;
  assign vga.o_hs    = inWindow(hCnt, H_SYNC_START, H_SYNC_END) ? HS_POL : ~HS_POL;
  assign vga.o_vs    = inWindow(vCnt, V_SYNC_START, V_SYNC_END) ? VS_POL : ~VS_POL;
  assign vga.o_de    = inWindow(hCnt, 0, H_ACTIVE) && inWindow(vCnt, 0, V_ACTIVE);
  assign vga.o_frame = (hCnt == '0) && (vCnt == '0);

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance (A) and a reduced-size
// instance with positive hsync (B), each checked against its own raster model.
module tb_vga_timing;

  // Instance A: default VGA timing.
  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int AHT = AHA + AHF + AHS + AHB;   // 800
  localparam int AVT = AVA + AVF + AVS + AVB;   // 525

  // Instance B: 22-cycle lines, 10-line frames, hsync active-high.
  localparam int BHA = 16, BHF = 2, BHS = 3, BHB = 1;
  localparam int BVA = 6,  BVF = 1, BVS = 2, BVB = 1;
  localparam int BHT = BHA + BHF + BHS + BHB;   // 22
  localparam int BVT = BVA + BVF + BVS + BVB;   // 10

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit de;
    bit frame;
  } exp_t;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;

  vga_timing_if ifA ();
  vga_timing_if ifB ();

  vga_timing dutA (
    .clk   (clk),
    .reset (rstA),
    .vga   (ifA)
  );

  vga_timing #(
    .H_ACTIVE (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_ACTIVE (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) dutB (
    .clk   (clk),
    .reset (rstB),
    .vga   (ifB)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  exp_t sbA[$];
  exp_t sbB[$];

  int mhA, mvA, mhB, mvB;

  // Tallies over line 0 of A and frame 0 of B.
  int stateIdx  = 0;
  int hsLowA    = 0;
  int deA       = 0;
  int vsLowA    = 0;
  int frameA    = 0;
  int hsHighB   = 0;
  int vsLowB    = 0;
  int deB       = 0;
  int frameB    = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t decode(int h, int v, int ha, int hf, int hsw, int va, int vf, int vsw,
                                  bit hp, bit vp);
    exp_t e;
    e.h     = h;
    e.v     = v;
    e.hs    = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    e.vs    = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    e.de    = (h < ha) && (v < va);
    e.frame = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic compareOut(input string pfx, input exp_t e, input logic [11:0] h, input logic [11:0] v,
                            input logic hs, input logic vs, input logic de, input logic fr);
    check({pfx, ".h"},     32'(h),  32'(e.h));
    check({pfx, ".v"},     32'(v),  32'(e.v));
    check({pfx, ".hs"},    32'(hs), 32'(e.hs));
    check({pfx, ".vs"},    32'(vs), 32'(e.vs));
    check({pfx, ".de"},    32'(de), 32'(e.de));
    check({pfx, ".frame"}, 32'(fr), 32'(e.frame));
  endtask

  // Advance both models, queue expectations, clock once, then compare.
  task automatic cycle(input bit ra, input bit rb);
    exp_t ea, eb;
    rstA = ra;
    rstB = rb;
    if (ra) begin
      mhA = 0; mvA = 0;
    end else if (mhA == AHT - 1) begin
      mhA = 0; mvA = (mvA == AVT - 1) ? 0 : mvA + 1;
    end else begin
      mhA++;
    end
    if (rb) begin
      mhB = 0; mvB = 0;
    end else if (mhB == BHT - 1) begin
      mhB = 0; mvB = (mvB == BVT - 1) ? 0 : mvB + 1;
    end else begin
      mhB++;
    end
    sbA.push_back(decode(mhA, mvA, AHA, AHF, AHS, AVA, AVF, AVS, 1'b0, 1'b0));
    sbB.push_back(decode(mhB, mvB, BHA, BHF, BHS, BVA, BVF, BVS, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    ea = sbA.pop_front();
    eb = sbB.pop_front();
    compareOut("A", ea, ifA.o_h, ifA.o_v, ifA.o_hs, ifA.o_vs, ifA.o_de, ifA.o_frame);
    compareOut("B", eb, ifB.o_h, ifB.o_v, ifB.o_hs, ifB.o_vs, ifB.o_de, ifB.o_frame);
  endtask

  // Count region occupancy; window bounds come from the model's position.
  task automatic tally();
    if (mvA == 0) begin
      if (ifA.o_hs === 1'b0) hsLowA++;
      if (ifA.o_de === 1'b1) deA++;
      if (ifA.o_vs === 1'b0) vsLowA++;
      if (ifA.o_frame === 1'b1) frameA++;
    end
    if (stateIdx < BHT * BVT) begin
      if (mvB == 0 && ifB.o_hs === 1'b1) hsHighB++;
      if (ifB.o_vs === 1'b0) vsLowB++;
      if (ifB.o_de === 1'b1) deB++;
      if (ifB.o_frame === 1'b1) frameB++;
    end
    stateIdx++;
  endtask

  initial begin
    int n;
    rstA = 1'b1;
    rstB = 1'b1;

    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);

    // First cycle after reset.
    check("A.rst.h",     32'(ifA.o_h),     32'd0);
    check("A.rst.v",     32'(ifA.o_v),     32'd0);
    check("A.rst.de",    32'(ifA.o_de),    32'd1);
    check("A.rst.frame", 32'(ifA.o_frame), 32'd1);
    check("A.rst.hs",    32'(ifA.o_hs),    32'd1);
    check("A.rst.vs",    32'(ifA.o_vs),    32'd1);
    check("B.rst.hs",    32'(ifB.o_hs),    32'd0);

    tally();
    for (int i = 1; i <= 900; i++) begin
      cycle(1'b0, 1'b0);
      tally();
      if (i == 799) begin
        check("A.lineEnd.h", 32'(ifA.o_h), 32'd799);
        check("A.lineEnd.v", 32'(ifA.o_v), 32'd0);
      end
      if (i == 800) begin
        check("A.wrap.h", 32'(ifA.o_h), 32'd0);
        check("A.wrap.v", 32'(ifA.o_v), 32'd1);
        check("A.wrap.frame", 32'(ifA.o_frame), 32'd0);
      end
      if (i == 18) check("B.hsRise", 32'(ifB.o_hs), 32'd1);
      if (i == 21) check("B.hsFall", 32'(ifB.o_hs), 32'd0);
      if (i == 22) check("B.lineWrap.h", 32'(ifB.o_h), 32'd0);
    end

    check("A.line0.hsLowCount", 32'(hsLowA), 32'd96);
    check("A.line0.deCount",    32'(deA),    32'd640);
    check("A.line0.vsLowCount", 32'(vsLowA), 32'd0);
    check("A.line0.frameCount", 32'(frameA), 32'd1);
    check("B.line0.hsHighCount", 32'(hsHighB), 32'd3);
    check("B.frame.vsLowCount",  32'(vsLowB),  32'(BVS * BHT));
    check("B.frame.deCount",     32'(deB),     32'(BHA * BVA));
    check("B.frame.frameCount",  32'(frameB),  32'd1);

    // Reset A mid-line (v=1 here; v=200 would cost 160k cycles).
    n = 0;
    while (!(mhA == 300 && mvA == 1) && n < 2000) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("A.preReset.h", 32'(ifA.o_h), 32'd300);
    cycle(1'b1, 1'b0);
    check("A.midReset.h",     32'(ifA.o_h),     32'd0);
    check("A.midReset.v",     32'(ifA.o_v),     32'd0);
    check("A.midReset.frame", 32'(ifA.o_frame), 32'd1);

    // Reset B mid-frame.
    n = 0;
    while (!(mhB == 10 && mvB == 4) && n < 300) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("B.preReset.h", 32'(ifB.o_h), 32'd10);
    check("B.preReset.v", 32'(ifB.o_v), 32'd4);
    cycle(1'b0, 1'b1);
    check("B.midReset.h",     32'(ifB.o_h),     32'd0);
    check("B.midReset.v",     32'(ifB.o_v),     32'd0);
    check("B.midReset.frame", 32'(ifB.o_frame), 32'd1);

    // Last pixel of the frame wraps to (0,0) with a frame pulse.
    n = 0;
    while (!(mhB == BHT - 1 && mvB == BVT - 1) && n < 300) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("B.lastPix.h",     32'(ifB.o_h),     32'd21);
    check("B.lastPix.v",     32'(ifB.o_v),     32'd9);
    check("B.lastPix.frame", 32'(ifB.o_frame), 32'd0);
    cycle(1'b0, 1'b0);
    check("B.frameWrap.h",     32'(ifB.o_h),     32'd0);
    check("B.frameWrap.v",     32'(ifB.o_v),     32'd0);
    check("B.frameWrap.frame", 32'(ifB.o_frame), 32'd1);

    check("sb.emptyA", 32'(sbA.size()), 32'd0);
    check("sb.emptyB", 32'(sbB.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: VGA

Interface
REQ-001 The block SHALL take parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 The block SHALL take parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 The block SHALL take parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical active, front porch, sync and back porch, in lines.
REQ-004 The block SHALL take parameters HS_POL 0 and VS_POL 0: sync asserted level, 0 = active-low.
REQ-005 clk  in  1  pixel clock, 25 MHz; the only clock.
REQ-006 reset  in  1  synchronous reset, active-high.
REQ-007 o_hs  out  1  horizontal sync.
REQ-008 o_vs  out  1  vertical sync.
REQ-009 o_frame  out  1  one-cycle start-of-frame pulse.
REQ-010 o_h  out  12  horizontal position; 0 = first active pixel.
REQ-011 o_v  out  12  vertical position; 0 = first active line.
REQ-012 o_de  out  1  display enable (active video).

Function
REQ-013 The horizontal counter SHALL increment every clk and wrap from H_TOTAL-1 (800-1 = 799) to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-014 The vertical counter SHALL increment only on the cycle where the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 (525-1 = 524) to 0, where V_TOTAL is the sum of the vertical parameters.
REQ-015 o_h and o_v SHALL be the registered counter values, zero-extended to 12 bits.
REQ-016 Region order per line SHALL be: active 0..639, front porch 640..655, sync 656..751, back porch 752..799; per frame: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 o_hs SHALL be at its asserted level (per HS_POL) exactly when H_ACTIVE+H_FP <= o_h < H_ACTIVE+H_FP+H_SYNC, and deasserted otherwise.
REQ-018 o_vs SHALL follow the same rule on o_v with the V parameters and VS_POL; o_vs depends on o_v only, independent of o_h.
REQ-019 o_de SHALL be 1 exactly when o_h < H_ACTIVE and o_v < V_ACTIVE.
REQ-020 o_frame SHALL be 1 exactly on the cycle where o_h == 0 and o_v == 0, i.e. once per 420000 cycles.
REQ-021 o_hs, o_vs, o_de and o_frame SHALL be combinational decodes of the counter registers: zero latency relative to o_h/o_v, no additional pipeline stage.
REQ-022 Counter arithmetic SHALL use at least 10 bits; the counters SHALL never reach H_TOTAL or V_TOTAL.

Reset
REQ-023 While reset is high at a clk edge, both counters SHALL load 0.
REQ-024 In the first cycle after reset: o_h=0, o_v=0, o_de=1, o_frame=1, o_hs and o_vs deasserted.
REQ-025 Reset asserted mid-line or mid-frame SHALL override any pending increment or wrap.
REQ-026 The block SHALL also initialise the counters to 0 at power-up for simulation.

Structure
REQ-027 The timing constants (totals, sync start/end) SHALL be localparams derived from the parameters; a shared package SHALL hold the default 640x480@60 values.
REQ-028 The design SHALL be a single module with no sub-modules; one counter-and-wrap per axis.

Verification
REQ-029 Reset, then run 800 cycles -> o_h steps 0..799 and wraps to 0; o_v increments 0 -> 1 exactly at the wrap.
REQ-030 Within line 0 -> o_hs low exactly for o_h = 656..751 (96 cycles), high elsewhere; o_de high for o_h = 0..639 only.
REQ-031 Over a full frame (420000 cycles) -> o_vs low only for o_v = 490..491 (1600 cycles); o_de low for all of o_v >= 480; o_frame pulses exactly once at (0,0).
REQ-032 Assert reset at o_h=300, o_v=200 -> next cycle o_h=0, o_v=0, o_frame=1.
REQ-033 At o_h=799, o_v=524 -> next cycle o_h=0, o_v=0, o_frame=1.
REQ-034 Instantiate with H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=1 and HS_POL=1 -> 22-cycle lines; o_hs high for o_h = 18..20.
